// File: rtl/fp32_pkg.sv
// Shared FP32 field layout, constants and sequencer states for the matrix
// datapath arithmetic units (multiplier and divider).
package fp32_pkg;
    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;
    localparam int WORD_W = SIGN_W + EXP_W + FRAC_W;

    localparam logic [WORD_W-1:0]  QNAN     = 32'h7FC0_0000;
    localparam logic signed [9:0]  EXP_BIAS = 10'sd127;
    localparam logic [EXP_W-1:0]   EXP_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        DIV  = 2'd2,
        PACK = 2'd3
    } fsm_state_t;
endpackage

// File: rtl/mant_div_restoring.sv
// 24-step restoring mantissa divider, one quotient bit per clock, MSB first.
// Dividend must already be normalised so the quotient lies in [1,2).
module mant_div_restoring
    import fp32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [MANT_W:0]   i_dividend,
    input  logic [MANT_W-1:0] i_divisor,
    output logic              o_done,
    output logic [FRAC_W-1:0] o_frac
);
    localparam logic [4:0] LAST_STEP = 5'(MANT_W - 1);

    logic [MANT_W:0]   r_rem;
    logic [MANT_W-1:0] r_dvs;
    logic [FRAC_W-1:0] r_quot;
    logic [4:0]        r_cnt;
    logic              r_run;

    logic              w_ge;
    logic [MANT_W:0]   w_diff;
    logic [MANT_W:0]   w_sel;

    assign w_ge   = (r_rem >= {1'b0, r_dvs});
    assign w_diff = r_rem - {1'b0, r_dvs};
    assign w_sel  = w_ge ? w_diff : r_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_dvs  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
        end else if (i_start) begin
            r_rem  <= i_dividend;
            r_dvs  <= i_divisor;
            r_quot <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b1;
        end else if (r_run) begin
            // The leading quotient bit (always 1) falls off the 23-bit
            // register after 24 shifts, leaving just the fraction.
            r_quot <= {r_quot[FRAC_W-2:0], w_ge};
            r_rem  <= {w_sel[MANT_W-1:0], 1'b0};
            r_cnt  <= r_cnt + 5'd1;
            if (r_cnt == LAST_STEP) begin
                r_run <= 1'b0;
            end
        end
    end

    // High during the final iteration, so the caller can leave its wait
    // state on the same edge that the last quotient bit lands.
    assign o_done = r_run && (r_cnt == LAST_STEP);
    assign o_frac = r_quot;
endmodule

// File: rtl/fp32_divider_seq.sv
// Sequential FP32 divider: classify/unpack at accept, restoring mantissa
// divide, then pack with truncation, overflow and divide-by-zero flags.
module fp32_divider_seq
    import fp32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_vld,
    output logic              o_busy,
    output logic [WORD_W-1:0] o_res,
    output logic              o_res_vld,
    output logic              overflow,
    output logic              div_by_zero
);
    fsm_state_t r_state, w_state_next;

    logic              w_sign;
    logic [EXP_W-1:0]  w_ea, w_eb;
    logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic              w_spec, w_spec_ov, w_spec_dbz;
    logic [WORD_W-1:0] w_spec_res;
    logic signed [9:0] w_exp_acc;

    logic              r_sign, r_special, r_spec_ov, r_spec_dbz;
    logic [WORD_W-1:0] r_spec_res;
    logic signed [9:0] r_exp;
    logic [MANT_W-1:0] r_ma, r_mb;

    logic              w_ma_lt;
    logic [MANT_W:0]   w_dividend;
    logic              w_div_start, w_div_done, w_out_load;
    logic [FRAC_W-1:0] w_frac;
    logic [WORD_W-1:0] w_norm_res;
    logic              w_norm_ov;

    assign w_sign   = i_a[WORD_W-1] ^ i_b[WORD_W-1];
    assign w_ea     = i_a[FRAC_W +: EXP_W];
    assign w_eb     = i_b[FRAC_W +: EXP_W];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == EXP_MAX) && (i_a[FRAC_W-1:0] == '0);
    assign w_b_inf  = (w_eb == EXP_MAX) && (i_b[FRAC_W-1:0] == '0);
    assign w_a_nan  = (w_ea == EXP_MAX) && (i_a[FRAC_W-1:0] != '0);
    assign w_b_nan  = (w_eb == EXP_MAX) && (i_b[FRAC_W-1:0] != '0);
    assign w_exp_acc = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + EXP_BIAS;

    // Special operands in priority order; subnormals already count as zero.
    always_comb begin
        w_spec     = 1'b1;
        w_spec_res = QNAN;
        w_spec_ov  = 1'b1;
        w_spec_dbz = 1'b0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_res = QNAN;
        end else if (w_a_inf) begin
            w_spec_res = {w_sign, EXP_MAX, {FRAC_W{1'b0}}};
        end else if (w_b_inf) begin
            w_spec_res = {w_sign, {(WORD_W-1){1'b0}}};
            w_spec_ov  = 1'b0;
        end else if (w_b_zero) begin
            w_spec_res = {w_sign, EXP_MAX, {FRAC_W{1'b0}}};
            w_spec_dbz = 1'b1;
        end else if (w_a_zero) begin
            w_spec_res = {w_sign, {(WORD_W-1){1'b0}}};
            w_spec_ov  = 1'b0;
        end else begin
            w_spec     = 1'b0;
            w_spec_res = '0;
            w_spec_ov  = 1'b0;
        end
    end

    assign w_ma_lt    = (r_ma < r_mb);
    assign w_dividend = w_ma_lt ? {r_ma, 1'b0} : {1'b0, r_ma};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_div_start  = 1'b0;
        w_out_load   = 1'b0;
        case (r_state)
            IDLE: if (i_vld) w_state_next = w_spec ? PACK : PREP;
            PREP: begin
                w_div_start  = 1'b1;
                w_state_next = DIV;
            end
            DIV:  if (w_div_done) w_state_next = PACK;
            PACK: begin
                w_out_load   = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_busy = (r_state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign     <= 1'b0;
            r_special  <= 1'b0;
            r_spec_res <= '0;
            r_spec_ov  <= 1'b0;
            r_spec_dbz <= 1'b0;
            r_exp      <= '0;
            r_ma       <= '0;
            r_mb       <= '0;
        end else if (r_state == IDLE && i_vld) begin
            r_sign     <= w_sign;
            r_special  <= w_spec;
            r_spec_res <= w_spec_res;
            r_spec_ov  <= w_spec_ov;
            r_spec_dbz <= w_spec_dbz;
            r_exp      <= w_exp_acc;
            r_ma       <= {1'b1, i_a[FRAC_W-1:0]};
            r_mb       <= {1'b1, i_b[FRAC_W-1:0]};
        end else if (r_state == PREP && w_ma_lt) begin
            r_exp <= r_exp - 10'sd1;
        end
    end

    mant_div_restoring u_mant_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_dividend),
        .i_divisor  (r_mb),
        .o_done     (w_div_done),
        .o_frac     (w_frac)
    );

    always_comb begin
        w_norm_ov  = 1'b0;
        w_norm_res = {r_sign, r_exp[EXP_W-1:0], w_frac};
        if (r_exp >= 10'sd255) begin
            w_norm_res = {r_sign, EXP_MAX, {FRAC_W{1'b0}}};
            w_norm_ov  = 1'b1;
        end else if (r_exp <= 10'sd0) begin
            w_norm_res = {r_sign, {(WORD_W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_res       <= '0;
            o_res_vld   <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            o_res_vld <= w_out_load;
            if (w_out_load) begin
                o_res       <= r_special ? r_spec_res : w_norm_res;
                overflow    <= r_special ? r_spec_ov  : w_norm_ov;
                div_by_zero <= r_special && r_spec_dbz;
            end
        end
    end
endmodule

// File: tb/tb_fp32_divider_seq.sv
// Directed bench for fp32_divider_seq: expectations are queued at issue time
// and a forked monitor pops and compares each result strobe.
module tb_fp32_divider_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_a, i_b;
    logic        i_vld;
    logic        o_busy, o_res_vld, overflow, div_by_zero;
    logic [31:0] o_res;

    typedef struct {
        logic [31:0] res;
        logic        ov;
        logic        dbz;
        int          at;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    fp32_divider_seq dut (
        .clk         (clk),
        .rst         (rst),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_vld       (i_vld),
        .o_busy      (o_busy),
        .o_res       (o_res),
        .o_res_vld   (o_res_vld),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_res_vld === 1'b1) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_result: got %h required none", o_res);
                end else begin
                    e = sb.pop_front();
                    chk({e.nm, " res"}, o_res, e.res);
                    chk({e.nm, " ovf"}, 32'(overflow), 32'(e.ov));
                    chk({e.nm, " dbz"}, 32'(div_by_zero), 32'(e.dbz));
                    chk({e.nm, " lat"}, cyc, e.at);
                    $display("result %s: res=%h ovf=%0b dbz=%0b cyc=%0d", e.nm, o_res, overflow, div_by_zero, cyc);
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (o_busy) chk("idle_timeout", 32'(o_busy), 32'd0);
    endtask

    // Called at a negedge; the following posedge is the accept edge.
    task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] res, input logic ov,
                         input logic dbz, input int lat);
        exp_t e;
        wait_idle();
        i_a   = a;
        i_b   = b;
        i_vld = 1'b1;
        if (push) begin
            e.res = res;
            e.ov  = ov;
            e.dbz = dbz;
            e.at  = cyc + 1 + lat;
            e.nm  = nm;
            sb.push_back(e);
        end
        @(negedge clk);
        i_vld = 1'b0;
    endtask

    initial begin
        int n;
        i_a   = '0;
        i_b   = '0;
        i_vld = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("rst o_res", o_res, 32'd0);
        chk("rst o_res_vld", 32'(o_res_vld), 32'd0);
        chk("rst o_busy", 32'(o_busy), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        chk("rst div_by_zero", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue("6/2", 32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, 1'b0, 1'b0, 26);
        chk("busy after accept", 32'(o_busy), 32'd1);
        issue("-6/2", 32'hC0C00000, 32'h40000000, 1'b1, 32'hC0400000, 1'b0, 1'b0, 26);
        issue("1/1", 32'h3F800000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, 26);

        // Operands offered while busy must be dropped.
        repeat (4) @(negedge clk);
        i_a   = 32'h40000000;
        i_b   = 32'h3F800000;
        i_vld = 1'b1;
        @(negedge clk);
        i_vld = 1'b0;

        wait_idle();
        chk("b2b strobe", 32'(o_res_vld), 32'd1);
        issue("1/3", 32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAA, 1'b0, 1'b0, 26);

        issue("nan/1", 32'h7FC00001, 32'h3F800000, 1'b1, 32'h7FC00000, 1'b1, 1'b0, 1);
        issue("0/0", 32'h00000000, 32'h00000000, 1'b1, 32'h7FC00000, 1'b1, 1'b0, 1);
        issue("2/inf", 32'h40000000, 32'h7F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1);
        issue("big/small", 32'h7F000000, 32'h00800000, 1'b1, 32'h7F800000, 1'b1, 1'b0, 26);
        issue("small/2", 32'h00800000, 32'h40000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 26);
        issue("1/0", 32'h3F800000, 32'h00000000, 1'b1, 32'h7F800000, 1'b1, 1'b1, 1);

        // Reset in the middle of the 11th divide iteration drops the operation.
        wait_idle();
        chk("pre-rst o_res", o_res, 32'h7F800000);
        chk("pre-rst div_by_zero", 32'(div_by_zero), 32'd1);
        issue("rst victim", 32'h40C00000, 32'h40000000, 1'b0, 32'd0, 1'b0, 1'b0, 26);
        repeat (11) @(negedge clk);
        chk("busy mid div", 32'(o_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid-rst o_res", o_res, 32'd0);
        chk("mid-rst o_res_vld", 32'(o_res_vld), 32'd0);
        chk("mid-rst o_busy", 32'(o_busy), 32'd0);
        chk("mid-rst overflow", 32'(overflow), 32'd0);
        chk("mid-rst div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("post-rst idle", 32'(o_busy), 32'd0);

        issue("6/2 after rst", 32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, 1'b0, 1'b0, 26);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
